register_arbiter: RTL and testbench
===================================

REGISTER_ARBITER -- requirements
Module: register_arbiter

Interface
REQ-001 Parameter NREQ, default 4: number of requesters sharing the register.
REQ-002 Parameter WIDTH, default 8: register data width.
REQ-003 Parameter MAXBURST, default 4: maximum consecutive locked writes by one owner.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst_  input  1  reset; synchronous, active-high.
REQ-006 req  input  NREQ  per-requester write request; held until transfer.
REQ-007 lock  input  NREQ  per-requester burst-lock request, qualified by req.
REQ-008 wdata  input  NREQ x WIDTH  per-requester write data, stable while req high.
REQ-009 gnt  output  NREQ  registered one-hot grant; all-zero when no grant.
REQ-010 owner  output  clog2(NREQ)  index of the current or last granted requester.
REQ-011 out  output  WIDTH  shared register contents.
REQ-012 busy  output  1  high while state is not IDLE.

Function
REQ-013 States: IDLE (gnt=0), GRANT (single grant), LOCKED (burst grant to same owner).
REQ-014 A transfer occurs on a rising edge where req[owner] & gnt[owner]; out <= wdata[owner] on that edge, with no other path updating out.
REQ-015 gnt high with req[owner] low is a lost cycle: no write, out held.
REQ-016 Arbitration each edge in IDLE/GRANT: round-robin over req, search starting at pointer ptr, first set bit wins.
REQ-017 Winner: gnt one-hot next cycle, owner <= winner, state <= GRANT; no req -> gnt <= 0, state <= IDLE.
REQ-018 After each transfer in GRANT, ptr <= owner+1 modulo NREQ (wrap NREQ-1 -> 0).
REQ-019 Transfer with lock[owner] high in GRANT -> state LOCKED, same owner, burst count <= 1.
REQ-020 LOCKED: each transfer increments burst count; gnt stays on owner while req[owner] & lock[owner] and count < MAXBURST.
REQ-021 LOCKED exit (lock drop, req drop, or count reaching MAXBURST): ptr <= owner+1, arbitrate same edge per REQ-016/017, count <= 0.
REQ-022 Latency: req rising in IDLE at edge N -> gnt high in cycle after N -> out updated at edge N+1.
REQ-023 Back-to-back: a new grant may follow a transfer with no idle cycle.
REQ-024 gnt shall never have more than one bit set; owner always equals index of set gnt bit.
REQ-025 lock without req is ignored.

Reset
REQ-026 rst_ high at a rising edge: out=0, gnt=0, owner=0, ptr=0, burst count=0, state IDLE, busy=0.
REQ-027 rst_ mid-grant or mid-burst: no write on that edge; gnt=0 from the next cycle.
REQ-028 rst_ has priority over simultaneous transfer.

Structure
REQ-029 Shared package register_arb_pkg holds the state enum (IDLE, GRANT, LOCKED) and default parameter constants.
REQ-030 Sub-module rr_picker: combinational round-robin selection (req, ptr -> winner index, valid).

Verification
REQ-031 Reset then req=0001, wdata[0]=8'hA5 -> gnt=0001 next cycle, out=8'hA5 after that edge, busy=1 during grant.
REQ-032 req=1111 held, lock=0, distinct wdata 11/22/33/44 -> gnt order 0001,0010,0100,1000,0001; out follows 11,22,33,44.
REQ-033 req=0011, lock[1]=1, ptr at 1 -> four consecutive transfers by 1 (MAXBURST), then gnt=0001.
REQ-034 req[2] dropped while gnt=0100 -> no write, out unchanged, gnt moves to next requester or 0.
REQ-035 rst_ asserted during LOCKED burst with wdata=8'hFF -> out=8'h00, gnt=0, state IDLE next cycle.
REQ-036 Random req/lock/wdata for 500 cycles -> gnt one-hot or zero, out matches reference model, no requester starved beyond (NREQ-1)*MAXBURST+1 cycles.

Source files
------------

// File: rtl/register_arb_pkg.sv
// Shared definitions for the register arbiter: FSM state encoding and
// default sizing constants.
package register_arb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      GRANT  = 2'd1,
      LOCKED = 2'd2
   } arb_state_e;

   localparam int DEF_NREQ     = 4;
   localparam int DEF_WIDTH    = 8;
   localparam int DEF_MAXBURST = 4;

endpackage

// File: rtl/register_arbiter_rr_picker.sv
// Combinational round-robin picker: the first set request at or after ptr
// (wrapping) wins; valid is low when no request is set.
module rr_picker #(
   parameter int NREQ = 4,
   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic [NREQ-1:0] req,
   input  logic [PW-1:0]   ptr,
   output logic [PW-1:0]   winner,
   output logic            valid
);

   logic [PW-1:0] idx;

   // Scan from farthest to nearest so the nearest set bit is written last.
   always_comb begin
      winner = '0;
      valid  = 1'b0;
      idx    = '0;
      for (int i = NREQ - 1; i >= 0; i--) begin
         idx = PW'((int'(ptr) + i) % NREQ);
         if (req[idx]) begin
            winner = idx;
            valid  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/register_arbiter.sv
// Shared-register arbiter: round-robin single grants with optional locked
// bursts of up to MAXBURST writes by one owner.
module register_arbiter
   import register_arb_pkg::*;
#(
   parameter int NREQ     = DEF_NREQ,
   parameter int WIDTH    = DEF_WIDTH,
   parameter int MAXBURST = DEF_MAXBURST,
   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic                       clk,
   input  logic                       rst_,
   input  logic [NREQ-1:0]            req,
   input  logic [NREQ-1:0]            lock,
   input  logic [NREQ-1:0][WIDTH-1:0] wdata,
   output logic [NREQ-1:0]            gnt,
   output logic [PW-1:0]              owner,
   output logic [WIDTH-1:0]           out,
   output logic                       busy
);

   localparam int CW = $clog2(MAXBURST + 1);

   arb_state_e      state_q, state_d;
   logic [NREQ-1:0] gnt_q, gnt_d;
   logic [PW-1:0]   owner_q, owner_d;
   logic [PW-1:0]   ptr_q, ptr_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [WIDTH-1:0] out_q, out_d;

   logic            xfer;
   logic            rearb;
   logic [PW-1:0]   nxt_owner;
   logic [PW-1:0]   pick_ptr;
   logic [PW-1:0]   win;
   logic            win_v;

   rr_picker #(.NREQ(NREQ)) u_picker (
      .req    (req),
      .ptr    (pick_ptr),
      .winner (win),
      .valid  (win_v)
   );

   always_comb begin
      state_d  = state_q;
      gnt_d    = gnt_q;
      owner_d  = owner_q;
      ptr_d    = ptr_q;
      cnt_d    = cnt_q;
      out_d    = out_q;
      rearb    = 1'b1;
      pick_ptr = ptr_q;

      nxt_owner = (owner_q == PW'(NREQ - 1)) ? '0 : owner_q + PW'(1);
      xfer      = (state_q != IDLE) && req[owner_q];

      if (xfer) begin
         out_d = wdata[owner_q];
      end

      // The pointer moves past the owner on the same edge it is used, so a
      // finished owner never wins the immediately following arbitration first.
      case (state_q)
         LOCKED: begin
            if (xfer && lock[owner_q] && (int'(cnt_q) + 1 < MAXBURST)) begin
               cnt_d = cnt_q + CW'(1);
               rearb = 1'b0;
            end else begin
               cnt_d    = '0;
               ptr_d    = nxt_owner;
               pick_ptr = nxt_owner;
            end
         end
         default: begin
            if (xfer) begin
               ptr_d    = nxt_owner;
               pick_ptr = nxt_owner;
               if (lock[owner_q] && (MAXBURST > 1)) begin
                  state_d = LOCKED;
                  cnt_d   = CW'(1);
                  rearb   = 1'b0;
               end
            end
         end
      endcase

      if (rearb) begin
         gnt_d = '0;
         if (win_v) begin
            state_d    = GRANT;
            owner_d    = win;
            gnt_d[win] = 1'b1;
         end else begin
            state_d = IDLE;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst_) begin
         state_q <= IDLE;
         gnt_q   <= '0;
         owner_q <= '0;
         ptr_q   <= '0;
         cnt_q   <= '0;
         out_q   <= '0;
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         owner_q <= owner_d;
         ptr_q   <= ptr_d;
         cnt_q   <= cnt_d;
         out_q   <= out_d;
      end
   end

   assign gnt   = gnt_q;
   assign owner = owner_q;
   assign out   = out_q;
   assign busy  = (state_q != IDLE);

endmodule

// File: tb/tb_register_arbiter.sv
// Directed and randomized bench for register_arbiter, compared every cycle
// against a procedural model of the arbitration rules.
module tb_register_arbiter;

   localparam int NREQ     = 4;
   localparam int WIDTH    = 8;
   localparam int MAXBURST = 4;
   localparam int BOUND    = (NREQ - 1) * MAXBURST + 1;

   logic                       clk = 1'b0;
   logic                       rst_ = 1'b0;
   logic [NREQ-1:0]            req = '0;
   logic [NREQ-1:0]            lock = '0;
   logic [NREQ-1:0][WIDTH-1:0] wdata = '0;
   logic [NREQ-1:0]            gnt;
   logic [1:0]                 owner;
   logic [WIDTH-1:0]           out;
   logic                       busy;

   int checks = 0;
   int failures = 0;

   // model: who holds the grant, whether in a burst, burst length, rr pointer
   bit         m_gv, m_lockd;
   int         m_own, m_ptr, m_cnt, m_xfer_id;
   logic [7:0] m_out;
   int         waitc [NREQ];

   register_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .MAXBURST(MAXBURST)) dut (
      .clk   (clk),
      .rst_  (rst_),
      .req   (req),
      .lock  (lock),
      .wdata (wdata),
      .gnt   (gnt),
      .owner (owner),
      .out   (out),
      .busy  (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_update();
      bit xfer, rearb;
      int start;
      m_xfer_id = -1;
      if (rst_) begin
         m_gv = 0; m_lockd = 0; m_own = 0; m_ptr = 0; m_cnt = 0; m_out = '0;
         return;
      end
      xfer  = m_gv && req[m_own];
      rearb = 1;
      if (xfer) begin
         m_out     = wdata[m_own];
         m_xfer_id = m_own;
      end
      if (m_lockd) begin
         if (xfer && lock[m_own] && m_cnt + 1 < MAXBURST) begin
            m_cnt++;
            rearb = 0;
         end else begin
            m_lockd = 0;
            m_cnt   = 0;
            m_ptr   = (m_own + 1) % NREQ;
         end
      end else if (xfer) begin
         m_ptr = (m_own + 1) % NREQ;
         if (lock[m_own]) begin
            m_lockd = 1;
            m_cnt   = 1;
            rearb   = 0;
         end
      end
      if (rearb) begin
         m_gv  = 0;
         start = m_ptr;
         for (int i = 0; i < NREQ; i++) begin
            if (!m_gv && req[(start + i) % NREQ]) begin
               m_gv  = 1;
               m_own = (start + i) % NREQ;
            end
         end
      end
   endtask

   task automatic step();
      @(posedge clk);
      model_update();
      #1;
      chk("gnt", gnt, m_gv ? (32'd1 << m_own) : 32'd0);
      chk("owner", owner, m_own);
      chk("out", out, m_out);
      chk("busy", busy, m_gv);
      chk("onehot0", $onehot0(gnt), 1);
   endtask

   task automatic do_reset();
      req = '0; lock = '0; rst_ = 1'b1;
      step();
      rst_ = 1'b0;
   endtask

   initial begin
      logic [3:0] gexp [5];
      logic [7:0] dat  [4];
      gexp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      dat  = '{8'h11, 8'h22, 8'h33, 8'h44};

      // reset state
      do_reset();
      chk("rst_gnt", gnt, 0);
      chk("rst_out", out, 0);
      chk("rst_busy", busy, 0);

      // single request latency
      req = 4'b0001; wdata[0] = 8'hA5;
      step();
      chk("single_gnt", gnt, 4'b0001);
      chk("single_busy", busy, 1);
      step();
      chk("single_out", out, 8'hA5);
      req = '0;
      step();

      // round robin rotation with all requesting
      do_reset();
      req = 4'b1111; wdata = {8'h44, 8'h33, 8'h22, 8'h11};
      for (int k = 0; k < 5; k++) begin
         step();
         chk("rr_gnt", gnt, gexp[k]);
         if (k > 0) chk("rr_out", out, dat[k-1]);
      end

      // locked burst by requester 1 capped at MAXBURST
      do_reset();
      req = 4'b0001; wdata[0] = 8'h5A;
      step();
      req = 4'b0011; lock = 4'b0010; wdata[1] = 8'h77;
      step();
      chk("burst_start", gnt, 4'b0010);
      for (int k = 1; k <= 4; k++) begin
         step();
         chk("burst_gnt", gnt, (k < 4) ? 4'b0010 : 4'b0001);
         chk("burst_out", out, 8'h77);
      end
      lock = '0;

      // request dropped while granted: lost cycle
      do_reset();
      req = 4'b0100; wdata[2] = 8'h3C;
      step();
      chk("lost_gnt0", gnt, 4'b0100);
      req = 4'b1000; wdata[3] = 8'hC3;
      step();
      chk("lost_out", out, 0);
      chk("lost_gnt1", gnt, 4'b1000);
      step();
      chk("lost_next_out", out, 8'hC3);

      // reset during a locked burst
      do_reset();
      req = 4'b0001; lock = 4'b0001; wdata[0] = 8'hFF;
      step();
      step();
      step();
      chk("burst_busy", busy, 1);
      rst_ = 1'b1;
      step();
      chk("rstburst_out", out, 0);
      chk("rstburst_gnt", gnt, 0);
      chk("rstburst_busy", busy, 0);
      rst_ = 1'b0;
      req = '0; lock = '0;

      // randomized traffic, requests held until their transfer
      do_reset();
      for (int i = 0; i < NREQ; i++) waitc[i] = 0;
      for (int cyc = 0; cyc < 500; cyc++) begin
         for (int i = 0; i < NREQ; i++) begin
            if (!req[i] || m_xfer_id == i) begin
               req[i] = ($urandom_range(0, 2) == 0);
               lock[i] = $urandom_range(0, 1) == 1;
               wdata[i] = 8'($urandom);
            end
            if (req[i] && !gnt[i]) waitc[i]++;
            else waitc[i] = 0;
            chk("starve", waitc[i] <= BOUND, 1);
         end
         step();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
